// File: rtl/tm1637_frame_ctrl.sv
// Purpose: whole-frame TM1637 controller (data cmd, addr+digits, display cmd) with its own two-wire bit engine; optional ACK_CHECK_EN aborts on NACK.
// Latency: busy from the cycle after an accepted update for (69+18*NUM_DIGITS)*CLK_DIV cycles; done pulses the first idle cycle.
// Backpressure: update is accepted only while idle; requests arriving while busy are dropped, never queued.
module tm1637_frame_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int CLK_DIV    = 50
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    update,
   input  logic [8*NUM_DIGITS-1:0] seg_data,
   input  logic [2:0]              brightness,
   input  logic                    display_on,
   output logic                    busy,
   output logic                    done,
   output logic                    ack_err,
   output logic                    scl_en,
   output logic                    scl_out,
   output logic                    sda_en,
   output logic                    sda_out,
   input  logic                    sda_in
);

   localparam int DIV_W = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BIT_LO, S_BIT_HI, S_ACK_LO, S_ACK_HI, S_STOP
   } state_t;

   state_t                  state_q, state_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [1:0]              phase_q, phase_d;   // sub-phase inside START / STOP
   logic [2:0]              bit_q, bit_d;
   logic [2:0]              byte_q, byte_d;     // byte index inside the transaction
   logic [1:0]              txn_q, txn_d;       // 0 data cmd, 1 address+digits, 2 display cmd
   logic                    abort_q, abort_d;
   logic                    done_q, done_d;
   logic                    ack_err_q, ack_err_d;
   logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
   logic [2:0]              bright_q, bright_d;
   logic                    on_q, on_d;

   logic                    phase_end;
   logic                    nack;
   logic [7:0]              cur_byte;
   logic [2:0]              last_byte;

   assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
   assign last_byte = (txn_q == 2'd1) ? 3'(NUM_DIGITS) : 3'd0;

`ifdef ACK_CHECK_EN
   assign nack = sda_in;
`else
   // ACK slot is still clocked, but the slave's answer is never looked at.
   logic unused_sda_in;
   assign unused_sda_in = sda_in;
   assign nack          = 1'b0;
`endif

   // Select the byte currently being shifted out from the transaction/byte position.
   always_comb begin
      cur_byte = 8'h40;
      case (txn_q)
         2'd0: cur_byte = 8'h40;
         2'd1: begin
            cur_byte = 8'hC0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
               if (byte_q == 3'(k + 1)) cur_byte = seg_q[8*k +: 8];
            end
         end
         default: cur_byte = {4'h8, on_q, bright_q};
      endcase
   end

   // Next-state, phase sequencing and line levels; levels depend only on registered state.
   always_comb begin
      state_d   = state_q;
      div_d     = (state_q == S_IDLE || phase_end) ? '0 : div_q + DIV_W'(1);
      phase_d   = phase_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      txn_d     = txn_q;
      abort_d   = abort_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
      seg_d     = seg_q;
      bright_d  = bright_q;
      on_d      = on_q;
      scl_out   = 1'b1;
      sda_out   = 1'b1;
      sda_en    = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (update) begin
               state_d   = S_START;
               phase_d   = 2'd0;
               bit_d     = 3'd0;
               byte_d    = 3'd0;
               txn_d     = 2'd0;
               abort_d   = 1'b0;
               ack_err_d = 1'b0;
               seg_d     = seg_data;
               bright_d  = brightness;
               on_d      = display_on;
            end
         end
         S_START: begin
            scl_out = (phase_q == 2'd0);
            sda_out = 1'b0;
            if (phase_end) begin
               if (phase_q == 2'd0) begin
                  phase_d = 2'd1;
               end else begin
                  state_d = S_BIT_LO;
                  bit_d   = 3'd0;
               end
            end
         end
         S_BIT_LO: begin
            scl_out = 1'b0;
            sda_out = cur_byte[bit_q];
            if (phase_end) state_d = S_BIT_HI;
         end
         S_BIT_HI: begin
            sda_out = cur_byte[bit_q];
            if (phase_end) begin
               if (bit_q == 3'd7) begin
                  state_d = S_ACK_LO;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  state_d = S_BIT_LO;
               end
            end
         end
         S_ACK_LO: begin
            scl_out = 1'b0;
            sda_en  = 1'b0;
            sda_out = 1'b0;
            if (phase_end) state_d = S_ACK_HI;
         end
         S_ACK_HI: begin
            sda_en  = 1'b0;
            sda_out = 1'b0;
            if (phase_end) begin
               if (nack) begin
                  ack_err_d = 1'b1;
                  abort_d   = 1'b1;
                  state_d   = S_STOP;
                  phase_d   = 2'd0;
               end else if (byte_q == last_byte) begin
                  state_d = S_STOP;
                  phase_d = 2'd0;
               end else begin
                  byte_d  = byte_q + 3'd1;
                  bit_d   = 3'd0;
                  state_d = S_BIT_LO;
               end
            end
         end
         S_STOP: begin
            scl_out = (phase_q != 2'd0);
            sda_out = (phase_q == 2'd2);
            if (phase_end) begin
               if (phase_q != 2'd2) begin
                  phase_d = phase_q + 2'd1;
               end else if (abort_q || txn_q == 2'd2) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  txn_d   = txn_q + 2'd1;
                  byte_d  = 3'd0;
                  phase_d = 2'd0;
                  state_d = S_START;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset returns the bus to idle-high immediately without a stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         phase_q   <= 2'd0;
         bit_q     <= 3'd0;
         byte_q    <= 3'd0;
         txn_q     <= 2'd0;
         abort_q   <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         seg_q     <= '0;
         bright_q  <= 3'd0;
         on_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         txn_q     <= txn_d;
         abort_q   <= abort_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         seg_q     <= seg_d;
         bright_q  <= bright_d;
         on_q      <= on_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign ack_err = ack_err_q;
   assign scl_en  = 1'b1;

endmodule
